// File: rtl/bill_pay_pkg.sv
// Shared types and helpers for the multi-channel bill payment engine.
// States, result codes and a width-generic saturating adder.
package bill_pay_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    CLOSE = 2'd2
  } state_t;

  localparam logic [1:0] RC_OK       = 2'd0;
  localparam logic [1:0] RC_BAD_NUM  = 2'd1;
  localparam logic [1:0] RC_BAD_MICR = 2'd2;
  localparam logic [1:0] RC_OVER     = 2'd3;

  // Result clamps at 2^w-1; callers narrow it back to w bits.
  function automatic logic [63:0] sat_add(
    input logic [63:0] a,
    input logic [63:0] b,
    input int unsigned w
  );
    logic [64:0] s;
    logic [63:0] m;
    m = {64{1'b1}} >> (64 - w);
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, m}) ? m : s[63:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from a pointer.
// The pointer moves past the winner only when the grant is taken.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] winner
);

  logic [IW-1:0] ptr_q;
  logic          found;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (int'(ptr_q) + k) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        winner   = IW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (winner == IW'(N - 1)) ? '0 : winner + IW'(1);
    end
  end

endmodule

// File: rtl/bill_payment_engine.sv
// Billing-cycle engine: arbitrates payment channels, validates each winner
// and accumulates accepted amounts, issuing a statement when the cycle closes.
module bill_payment_engine
  import bill_pay_pkg::*;
#(
  parameter int             NCH           = 3,
  parameter int             AMT_W         = 32,
  parameter int             NUM_W         = 32,
  parameter int             MICR_W        = 16,
  parameter logic [NCH-1:0] MICR_MASK     = 3'b010,
  parameter bit             ALLOW_OVERPAY = 1'b1,
  localparam int            IW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bill_load,
  input  logic [AMT_W-1:0]        cur_bill,
  input  logic [AMT_W-1:0]        prev_balance,
  input  logic                    close_cycle,
  input  logic [NCH*NUM_W-1:0]    ref_number,
  input  logic [MICR_W-1:0]       ref_micr,
  input  logic [NCH-1:0]          pay_valid,
  output logic [NCH-1:0]          pay_ready,
  input  logic [NCH*NUM_W-1:0]    pay_number,
  input  logic [NCH*MICR_W-1:0]   pay_micr,
  input  logic [NCH*AMT_W-1:0]    pay_amount,
  output logic                    res_valid,
  output logic [IW-1:0]           res_ch,
  output logic [1:0]              res_code,
  output logic                    stmt_valid,
  output logic [AMT_W-1:0]        next_balance,
  output logic [AMT_W-1:0]        credit,
  output logic                    busy
);

  state_t           state_q, state_d;
  logic [AMT_W-1:0] owed_q, paid_q;
  logic [NCH-1:0]   grant;
  logic [IW-1:0]    win;
  logic             hs;
  logic [1:0]       code;

  logic [NUM_W-1:0]  num, rnum;
  logic [MICR_W-1:0] micr;
  logic [AMT_W-1:0]  amt;
  logic [AMT_W:0]    trial;

  // A close request wins over any payment offered in the same cycle.
  assign pay_ready = grant & {NCH{(state_q == OPEN) & ~close_cycle}};
  assign hs        = |(pay_valid & pay_ready);
  assign busy      = (state_q != IDLE);

  rr_arbiter #(.N(NCH)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (pay_valid),
    .advance (hs),
    .grant   (grant),
    .winner  (win)
  );

  assign num   = pay_number[win*NUM_W +: NUM_W];
  assign rnum  = ref_number[win*NUM_W +: NUM_W];
  assign micr  = pay_micr[win*MICR_W +: MICR_W];
  assign amt   = pay_amount[win*AMT_W +: AMT_W];
  assign trial = {1'b0, paid_q} + {1'b0, amt};

  always_comb begin
    code = RC_OK;
    if (num != rnum)
      code = RC_BAD_NUM;
    else if (MICR_MASK[win] && (micr != ref_micr))
      code = RC_BAD_MICR;
    else if ((amt == '0) || (!ALLOW_OVERPAY && (trial > {1'b0, owed_q})))
      code = RC_OVER;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bill_load) state_d = OPEN;
      OPEN:    if (close_cycle) state_d = CLOSE;
      CLOSE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owed_q       <= '0;
      paid_q       <= '0;
      res_valid    <= 1'b0;
      res_ch       <= '0;
      res_code     <= '0;
      stmt_valid   <= 1'b0;
      next_balance <= '0;
      credit       <= '0;
    end else begin
      state_q    <= state_d;
      res_valid  <= hs;
      stmt_valid <= (state_q == CLOSE);
      if (hs) begin
        res_ch   <= win;
        res_code <= code;
      end
      if ((state_q == IDLE) && bill_load) begin
        owed_q <= AMT_W'(sat_add(64'(prev_balance), 64'(cur_bill), AMT_W));
        paid_q <= '0;
      end else if (hs && (code == RC_OK)) begin
        paid_q <= AMT_W'(sat_add(64'(paid_q), 64'(amt), AMT_W));
      end
      if (state_q == CLOSE) begin
        next_balance <= (owed_q > paid_q) ? owed_q - paid_q : '0;
        credit       <= (paid_q > owed_q) ? paid_q - owed_q : '0;
      end
    end
  end

endmodule

// File: tb/tb_bill_payment_engine.sv
// Directed bench: two engines (overpay allowed / rejected) share stimulus,
// expected values are hand-computed per vector.
module tb_bill_payment_engine;

  localparam int NCH = 3;
  localparam int AW  = 32;
  localparam int NW  = 32;
  localparam int MW  = 16;

  logic              clk = 1'b0;
  logic              reset, bill_load, close_cycle;
  logic [AW-1:0]     cur_bill, prev_balance;
  logic [NCH*NW-1:0] ref_number, pay_number;
  logic [MW-1:0]     ref_micr;
  logic [NCH*MW-1:0] pay_micr;
  logic [NCH*AW-1:0] pay_amount;
  logic [NCH-1:0]    pay_valid;

  logic [NCH-1:0] pay_ready, pay_ready0;
  logic           res_valid, res_valid0;
  logic [1:0]     res_ch, res_ch0, res_code, res_code0;
  logic           stmt_valid, stmt_valid0, busy, busy0;
  logic [AW-1:0]  next_balance, next_balance0, credit, credit0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bill_payment_engine #(.ALLOW_OVERPAY(1'b1)) dut (
    .clk(clk), .reset(reset), .bill_load(bill_load),
    .cur_bill(cur_bill), .prev_balance(prev_balance),
    .close_cycle(close_cycle), .ref_number(ref_number),
    .ref_micr(ref_micr), .pay_valid(pay_valid), .pay_ready(pay_ready),
    .pay_number(pay_number), .pay_micr(pay_micr),
    .pay_amount(pay_amount), .res_valid(res_valid), .res_ch(res_ch),
    .res_code(res_code), .stmt_valid(stmt_valid),
    .next_balance(next_balance), .credit(credit), .busy(busy)
  );

  bill_payment_engine #(.ALLOW_OVERPAY(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bill_load(bill_load),
    .cur_bill(cur_bill), .prev_balance(prev_balance),
    .close_cycle(close_cycle), .ref_number(ref_number),
    .ref_micr(ref_micr), .pay_valid(pay_valid), .pay_ready(pay_ready0),
    .pay_number(pay_number), .pay_micr(pay_micr),
    .pay_amount(pay_amount), .res_valid(res_valid0), .res_ch(res_ch0),
    .res_code(res_code0), .stmt_valid(stmt_valid0),
    .next_balance(next_balance0), .credit(credit0), .busy(busy0)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pay(input int ch, input logic [31:0] num,
                         input logic [15:0] mi, input logic [31:0] amt);
    pay_number[ch*NW +: NW] = num;
    pay_micr[ch*MW +: MW]   = mi;
    pay_amount[ch*AW +: AW] = amt;
  endtask

  task automatic pay(input int ch, input logic [31:0] num,
                     input logic [15:0] mi, input logic [31:0] amt,
                     input logic [1:0] ec, input logic [1:0] ec0);
    set_pay(ch, num, mi, amt);
    pay_valid     = '0;
    pay_valid[ch] = 1'b1;
    #1;
    check("pay_ready", 64'(pay_ready), 64'(3'b001 << ch));
    tick();
    pay_valid = '0;
    check("res_valid", 64'(res_valid), 64'd1);
    check("res_ch", 64'(res_ch), 64'(ch));
    check("res_code", 64'(res_code), 64'(ec));
    check("res_code_nop", 64'(res_code0), 64'(ec0));
  endtask

  task automatic load(input logic [31:0] prev, input logic [31:0] cur);
    prev_balance = prev;
    cur_bill     = cur;
    bill_load    = 1'b1;
    tick();
    bill_load = 1'b0;
    check("busy_load", 64'(busy), 64'd1);
  endtask

  task automatic close(input logic [31:0] nb, input logic [31:0] cr,
                       input logic [31:0] nb0, input logic [31:0] cr0);
    close_cycle = 1'b1;
    tick();
    close_cycle = 1'b0;
    check("stmt_early", 64'(stmt_valid), 64'd0);
    tick();
    check("stmt_valid", 64'(stmt_valid), 64'd1);
    check("next_balance", 64'(next_balance), 64'(nb));
    check("credit", 64'(credit), 64'(cr));
    check("next_balance_nop", 64'(next_balance0), 64'(nb0));
    check("credit_nop", 64'(credit0), 64'(cr0));
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    bill_load    = 1'b0;
    close_cycle  = 1'b0;
    cur_bill     = '0;
    prev_balance = '0;
    pay_valid    = '0;
    pay_number   = '0;
    pay_micr     = '0;
    pay_amount   = '0;
    ref_micr     = 16'd9876;
    ref_number   = {32'd7777, 32'd5555, 32'd1234};
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_stmt", 64'(stmt_valid), 64'd0);
    check("rst_nb", 64'(next_balance), 64'd0);
    check("rst_credit", 64'(credit), 64'd0);
    check("rst_ready", 64'(pay_ready), 64'd0);

    // basic cycle, MICR and number rejects
    load(32'd100, 32'd500);
    pay(0, 32'd1234, 16'd0, 32'd200, 2'd0, 2'd0);
    pay(1, 32'd5555, 16'd9875, 32'd50, 2'd2, 2'd2);
    pay(2, 32'd1, 16'd0, 32'd50, 2'd1, 2'd1);
    close(32'd400, 32'd0, 32'd400, 32'd0);

    // round-robin with every channel requesting
    load(32'd0, 32'd1000);
    set_pay(0, 32'd1234, 16'd0, 32'd10);
    set_pay(1, 32'd5555, 16'd9876, 32'd10);
    set_pay(2, 32'd7777, 16'd0, 32'd10);
    pay_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_ready", 64'(pay_ready), 64'(3'b001 << (k % 3)));
      tick();
      check("rr_res_ch", 64'(res_ch), 64'(k % 3));
      check("rr_res_code", 64'(res_code), 64'd0);
    end
    pay_valid = '0;
    pay(1, 32'd5555, 16'd9876, 32'd0, 2'd3, 2'd3);
    close(32'd960, 32'd0, 32'd960, 32'd0);

    // overpayment
    load(32'd0, 32'd100);
    pay(0, 32'd1234, 16'd0, 32'd150, 2'd0, 2'd3);
    close(32'd0, 32'd50, 32'd100, 32'd0);

    // bill_load ignored while open; close collides with a payment
    load(32'd0, 32'd50);
    cur_bill  = 32'd999;
    bill_load = 1'b1;
    tick();
    bill_load = 1'b0;
    set_pay(0, 32'd1234, 16'd0, 32'd10);
    pay_valid   = 3'b001;
    close_cycle = 1'b1;
    #1;
    check("coll_ready", 64'(pay_ready), 64'd0);
    tick();
    close_cycle = 1'b0;
    check("coll_res_valid", 64'(res_valid), 64'd0);
    check("coll_ready_close", 64'(pay_ready), 64'd0);
    tick();
    pay_valid = '0;
    check("coll_stmt", 64'(stmt_valid), 64'd1);
    check("coll_nb", 64'(next_balance), 64'd50);
    check("coll_res_valid2", 64'(res_valid), 64'd0);

    // owed and paid saturation
    load(32'hFFFF_FFF0, 32'h20);
    pay(0, 32'd1234, 16'd0, 32'hFFFF_FFF8, 2'd0, 2'd0);
    pay(0, 32'd1234, 16'd0, 32'd10, 2'd0, 2'd3);
    close(32'd0, 32'd0, 32'd7, 32'd0);

    // reset mid-cycle drops the statement
    load(32'd0, 32'd300);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_nb", 64'(next_balance), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mid_rst_stmt", 64'(stmt_valid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
